// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI4 slave backed by a small word-addressed memory
// with independent write and read burst engines.
module axi_slave_mem #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int MEM_DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] slave_aw_addr,
    input  logic [7:0]                slave_aw_len,
    input  logic [2:0]                slave_aw_size,
    input  logic [1:0]                slave_aw_burst,
    input  logic [AXI_ID_WIDTH-1:0]   slave_aw_id,
    input  logic [AXI_USER_WIDTH-1:0] slave_aw_user,
    input  logic                      slave_aw_valid,
    input  logic [2:0]                slave_aw_prot,
    input  logic [3:0]                slave_aw_region,
    input  logic                      slave_aw_lock,
    input  logic [3:0]                slave_aw_cache,
    input  logic [3:0]                slave_aw_qos,
    output logic                      slave_aw_ready,
    input  logic [AXI_DATA_WIDTH-1:0] slave_w_data,
    input  logic [AXI_STRB_WIDTH-1:0] slave_w_strb,
    input  logic [AXI_USER_WIDTH-1:0] slave_w_user,
    input  logic                      slave_w_last,
    input  logic                      slave_w_valid,
    output logic                      slave_w_ready,
    output logic [1:0]                slave_b_resp,
    output logic [AXI_ID_WIDTH-1:0]   slave_b_id,
    output logic [AXI_USER_WIDTH-1:0] slave_b_user,
    output logic                      slave_b_valid,
    input  logic                      slave_b_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] slave_ar_addr,
    input  logic [7:0]                slave_ar_len,
    input  logic [2:0]                slave_ar_size,
    input  logic [1:0]                slave_ar_burst,
    input  logic [AXI_ID_WIDTH-1:0]   slave_ar_id,
    input  logic [AXI_USER_WIDTH-1:0] slave_ar_user,
    input  logic                      slave_ar_valid,
    input  logic [2:0]                slave_ar_prot,
    input  logic [3:0]                slave_ar_region,
    input  logic                      slave_ar_lock,
    input  logic [3:0]                slave_ar_cache,
    input  logic [3:0]                slave_ar_qos,
    output logic                      slave_ar_ready,
    output logic [AXI_DATA_WIDTH-1:0] slave_r_data,
    output logic [1:0]                slave_r_resp,
    output logic                      slave_r_last,
    output logic [AXI_ID_WIDTH-1:0]   slave_r_id,
    output logic [AXI_USER_WIDTH-1:0] slave_r_user,
    output logic                      slave_r_valid,
    input  logic                      slave_r_ready
);
    localparam int OFFS = $clog2(AXI_STRB_WIDTH);
    localparam int IDXW = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_DEPTH * AXI_STRB_WIDTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [IDXW-1:0] w_idx, r_idx, ar_idx;
    logic [7:0]      w_len, w_cnt, r_len, r_cnt;
    logic            w_err, r_err, aw_err, ar_err;
    logic            aw_hs, w_hs, b_hs, ar_hs, r_hs, w_cnt_done, w_end;

    logic unused_inputs;
    assign unused_inputs = ^{slave_aw_prot, slave_aw_region, slave_aw_lock, slave_aw_cache,
                             slave_aw_qos, slave_ar_prot, slave_ar_region, slave_ar_lock,
                             slave_ar_cache, slave_ar_qos, slave_w_user};

    function automatic logic burst_err(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                       input logic [1:0] burst, input logic [2:0] size);
        return (burst != 2'b01) || (size != 3'(OFFS)) || (addr >= MEM_BYTES);
    endfunction

    always_comb begin
        aw_hs      = slave_aw_valid && slave_aw_ready;
        w_hs       = slave_w_valid && slave_w_ready;
        b_hs       = slave_b_valid && slave_b_ready;
        ar_hs      = slave_ar_valid && slave_ar_ready;
        r_hs       = slave_r_valid && slave_r_ready;
        aw_err     = burst_err(slave_aw_addr, slave_aw_burst, slave_aw_size);
        ar_err     = burst_err(slave_ar_addr, slave_ar_burst, slave_ar_size);
        ar_idx     = slave_ar_addr[OFFS +: IDXW];
        w_cnt_done = (w_cnt == w_len);
        w_end      = w_hs && (slave_w_last || w_cnt_done);

        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_end) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase

        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && slave_r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Ready/valid are registered from the next state so they stay low through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state        <= W_IDLE;
            slave_aw_ready <= 1'b0;
            slave_w_ready  <= 1'b0;
            slave_b_valid  <= 1'b0;
            slave_b_id     <= '0;
            slave_b_user   <= '0;
            w_idx          <= '0;
            w_len          <= '0;
            w_cnt          <= '0;
            w_err          <= 1'b0;
        end else begin
            w_state        <= w_next;
            slave_aw_ready <= (w_next == W_IDLE);
            slave_w_ready  <= (w_next == W_DATA);
            slave_b_valid  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_idx        <= slave_aw_addr[OFFS +: IDXW];
                w_len        <= slave_aw_len;
                w_cnt        <= '0;
                w_err        <= aw_err;
                slave_b_id   <= slave_aw_id;
                slave_b_user <= slave_aw_user;
            end
            if (w_hs) begin
                w_idx <= w_idx + 1'b1;
                w_cnt <= w_cnt + 1'b1;
                if (w_end && (slave_w_last != w_cnt_done)) w_err <= 1'b1;
            end
        end
    end

    assign slave_b_resp = (slave_b_valid && w_err) ? 2'b10 : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst && w_hs && !w_err) begin
            for (int i = 0; i < AXI_STRB_WIDTH; i++) begin
                if (slave_w_strb[i]) mem[w_idx][i*8 +: 8] <= slave_w_data[i*8 +: 8];
            end
        end
    end

    // r_idx always points at the word to fetch for the following beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= R_IDLE;
            slave_ar_ready <= 1'b0;
            slave_r_valid  <= 1'b0;
            slave_r_last   <= 1'b0;
            slave_r_data   <= '0;
            slave_r_id     <= '0;
            slave_r_user   <= '0;
            r_idx          <= '0;
            r_len          <= '0;
            r_cnt          <= '0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= r_next;
            slave_ar_ready <= (r_next == R_IDLE);
            if (ar_hs) begin
                r_idx         <= ar_idx + 1'b1;
                r_len         <= slave_ar_len;
                r_cnt         <= '0;
                r_err         <= ar_err;
                slave_r_id    <= slave_ar_id;
                slave_r_user  <= slave_ar_user;
                slave_r_valid <= 1'b1;
                slave_r_last  <= (slave_ar_len == 8'd0);
                slave_r_data  <= ar_err ? '0 : mem[ar_idx];
            end else if (r_hs) begin
                if (slave_r_last) begin
                    slave_r_valid <= 1'b0;
                    slave_r_last  <= 1'b0;
                end else begin
                    r_idx        <= r_idx + 1'b1;
                    r_cnt        <= r_cnt + 1'b1;
                    slave_r_last <= ((r_cnt + 1'b1) == r_len);
                    slave_r_data <= r_err ? '0 : mem[r_idx];
                end
            end
        end
    end

    assign slave_r_resp = (slave_r_valid && r_err) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb/tb_axi_slave_mem.sv - table-driven, hand-sequenced and randomized checks of
// axi_slave_mem against a word-array reference model.
module tb_axi_slave_mem;
    localparam int AW = 32, DW = 64, IW = 10, UW = 6, SW = 8, DEPTH = 16, TMO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] slave_aw_addr = '0, slave_ar_addr = '0;
    logic [7:0]    slave_aw_len = '0, slave_ar_len = '0;
    logic [2:0]    slave_aw_size = '0, slave_ar_size = '0;
    logic [1:0]    slave_aw_burst = '0, slave_ar_burst = '0;
    logic [IW-1:0] slave_aw_id = '0, slave_ar_id = '0;
    logic [UW-1:0] slave_aw_user = '0, slave_ar_user = '0;
    logic          slave_aw_valid = 1'b0, slave_ar_valid = 1'b0;
    logic [2:0]    slave_aw_prot = '0, slave_ar_prot = '0;
    logic [3:0]    slave_aw_region = '0, slave_ar_region = '0;
    logic          slave_aw_lock = 1'b0, slave_ar_lock = 1'b0;
    logic [3:0]    slave_aw_cache = '0, slave_ar_cache = '0;
    logic [3:0]    slave_aw_qos = '0, slave_ar_qos = '0;
    logic          slave_aw_ready, slave_ar_ready;
    logic [DW-1:0] slave_w_data = '0;
    logic [SW-1:0] slave_w_strb = '0;
    logic [UW-1:0] slave_w_user = '0;
    logic          slave_w_last = 1'b0, slave_w_valid = 1'b0;
    logic          slave_w_ready;
    logic [1:0]    slave_b_resp;
    logic [IW-1:0] slave_b_id;
    logic [UW-1:0] slave_b_user;
    logic          slave_b_valid;
    logic          slave_b_ready = 1'b0;
    logic [DW-1:0] slave_r_data;
    logic [1:0]    slave_r_resp;
    logic          slave_r_last;
    logic [IW-1:0] slave_r_id;
    logic [UW-1:0] slave_r_user;
    logic          slave_r_valid;
    logic          slave_r_ready = 1'b0;

    always #5 clk = ~clk;

    axi_slave_mem dut (
        .clk(clk), .rst(rst),
        .slave_aw_addr(slave_aw_addr), .slave_aw_len(slave_aw_len), .slave_aw_size(slave_aw_size),
        .slave_aw_burst(slave_aw_burst), .slave_aw_id(slave_aw_id), .slave_aw_user(slave_aw_user),
        .slave_aw_valid(slave_aw_valid), .slave_aw_prot(slave_aw_prot), .slave_aw_region(slave_aw_region),
        .slave_aw_lock(slave_aw_lock), .slave_aw_cache(slave_aw_cache), .slave_aw_qos(slave_aw_qos),
        .slave_aw_ready(slave_aw_ready),
        .slave_w_data(slave_w_data), .slave_w_strb(slave_w_strb), .slave_w_user(slave_w_user),
        .slave_w_last(slave_w_last), .slave_w_valid(slave_w_valid), .slave_w_ready(slave_w_ready),
        .slave_b_resp(slave_b_resp), .slave_b_id(slave_b_id), .slave_b_user(slave_b_user),
        .slave_b_valid(slave_b_valid), .slave_b_ready(slave_b_ready),
        .slave_ar_addr(slave_ar_addr), .slave_ar_len(slave_ar_len), .slave_ar_size(slave_ar_size),
        .slave_ar_burst(slave_ar_burst), .slave_ar_id(slave_ar_id), .slave_ar_user(slave_ar_user),
        .slave_ar_valid(slave_ar_valid), .slave_ar_prot(slave_ar_prot), .slave_ar_region(slave_ar_region),
        .slave_ar_lock(slave_ar_lock), .slave_ar_cache(slave_ar_cache), .slave_ar_qos(slave_ar_qos),
        .slave_ar_ready(slave_ar_ready),
        .slave_r_data(slave_r_data), .slave_r_resp(slave_r_resp), .slave_r_last(slave_r_last),
        .slave_r_id(slave_r_id), .slave_r_user(slave_r_user), .slave_r_valid(slave_r_valid),
        .slave_r_ready(slave_r_ready)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [DW-1:0] model_mem [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [7:0]  strb;
        logic [63:0] data;
        logic [1:0]  resp;
        int          bstall;
        int          rstall_at;
        int          rstall_n;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake not seen within %0d cycles", name, TMO);
    endtask

    function automatic bit model_err(input logic [31:0] addr, input logic [1:0] burst, input logic [2:0] size);
        return (burst != 2'd1) || (size != 3'd3) || (addr >= 32'd128);
    endfunction

    function automatic int word_of(input logic [31:0] addr, input int k);
        return (int'(addr / 8) + k) % DEPTH;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] base, input int k);
        return base + 64'(k) * 64'h0101_0101_0101_0101;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input logic [2:0] size, input logic [7:0] strb, input logic [63:0] base);
        logic [63:0] d;
        if (!model_err(addr, burst, size)) begin
            for (int k = 0; k <= int'(len); k++) begin
                d = beat_data(base, k);
                for (int b = 0; b < 8; b++)
                    if (strb[b]) model_mem[word_of(addr, k)][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [IW-1:0] id, input logic [UW-1:0] user);
        int n;
        n = 0;
        slave_aw_addr = addr; slave_aw_len = len; slave_aw_burst = burst; slave_aw_size = size;
        slave_aw_id = id; slave_aw_user = user; slave_aw_valid = 1'b1;
        while (!slave_aw_ready && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timed_out("aw_handshake");
        @(posedge clk); #1;
        slave_aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [IW-1:0] id, input logic [UW-1:0] user);
        int n;
        n = 0;
        slave_ar_addr = addr; slave_ar_len = len; slave_ar_burst = burst; slave_ar_size = size;
        slave_ar_id = id; slave_ar_user = user; slave_ar_valid = 1'b1;
        while (!slave_ar_ready && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timed_out("ar_handshake");
        @(posedge clk); #1;
        slave_ar_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n;
        n = 0;
        slave_w_data = data; slave_w_strb = strb; slave_w_last = last; slave_w_valid = 1'b1;
        while (!slave_w_ready && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timed_out("w_handshake");
        @(posedge clk); #1;
        slave_w_valid = 1'b0; slave_w_last = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [7:0] strb, input logic [63:0] base,
                            input int last_at, input int bstall, input logic [1:0] exp_resp);
        logic [IW-1:0] id;
        logic [UW-1:0] user;
        int n;
        id = IW'($urandom_range(0, 1023));
        user = UW'($urandom_range(0, 63));
        send_aw(addr, len, burst, size, id, user);
        for (int k = 0; k <= last_at; k++) send_w(beat_data(base, k), strb, k == last_at);
        check("w_ready_after_last", slave_w_ready, 0);
        n = 0;
        while (!slave_b_valid && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) timed_out("b_valid");
        for (int c = 0; c < bstall; c++) begin
            @(posedge clk); #1;
            check("b_valid_held", slave_b_valid, 1);
            check("b_resp_held", slave_b_resp, exp_resp);
            check("aw_ready_in_resp", slave_aw_ready, 0);
        end
        check("b_resp", slave_b_resp, exp_resp);
        check("b_id", slave_b_id, id);
        check("b_user", slave_b_user, user);
        slave_b_ready = 1'b1;
        @(posedge clk); #1;
        slave_b_ready = 1'b0;
        check("b_valid_cleared", slave_b_valid, 0);
        check("aw_ready_after_b", slave_aw_ready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [1:0] exp_resp,
                           input int stall_at, input int stall_n);
        logic [IW-1:0] id;
        logic [UW-1:0] user;
        logic [63:0] exp;
        int n;
        id = IW'($urandom_range(0, 1023));
        user = UW'($urandom_range(0, 63));
        slave_r_ready = 1'b1;
        send_ar(addr, len, burst, size, id, user);
        for (int k = 0; k <= int'(len); k++) begin
            exp = (exp_resp != 2'b00) ? 64'd0 : model_mem[word_of(addr, k)];
            n = 0;
            while (!slave_r_valid && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) timed_out("r_valid");
            if (k == stall_at) begin
                slave_r_ready = 1'b0;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    check("r_valid_held", slave_r_valid, 1);
                    check("r_data_held", slave_r_data, exp);
                    check("r_last_held", slave_r_last, k == int'(len));
                    check("r_id_held", slave_r_id, id);
                end
                slave_r_ready = 1'b1;
            end
            check("r_data", slave_r_data, exp);
            check("r_resp", slave_r_resp, exp_resp);
            check("r_last", slave_r_last, k == int'(len));
            check("r_id", slave_r_id, id);
            check("r_user", slave_r_user, user);
            @(posedge clk); #1;
        end
        check("r_valid_after_final", slave_r_valid, 0);
        check("ar_ready_after_final", slave_ar_ready, 1);
        slave_r_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] old_w3, new_w3, d;
        logic [31:0] a;
        logic [7:0]  l;
        logic [1:0]  bu;
        logic [2:0]  sz;

        tbl[0] = '{32'h00, 8'd15, 2'd1, 3'd3, 8'hFF, 64'hA5A5_0000_0000_0000, 2'b00, 0, -1, 0};
        tbl[1] = '{32'h08, 8'd0,  2'd1, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 2'b00, 0, -1, 0};
        tbl[2] = '{32'h70, 8'd3,  2'd1, 3'd3, 8'h0F, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 5, 1, 3};
        tbl[3] = '{32'h80, 8'd1,  2'd1, 3'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 0, -1, 0};
        tbl[4] = '{32'h00, 8'd1,  2'd1, 3'd3, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b00, 0, -1, 0};
        tbl[5] = '{32'h10, 8'd2,  2'd0, 3'd3, 8'hFF, 64'h5555_AAAA_5555_AAAA, 2'b10, 2, 0, 2};
        tbl[6] = '{32'h18, 8'd0,  2'd1, 3'd2, 8'hFF, 64'h7777_7777_7777_7777, 2'b10, 0, -1, 0};
        tbl[7] = '{32'h20, 8'd1,  2'd2, 3'd3, 8'hFF, 64'h9999_9999_9999_9999, 2'b10, 0, -1, 0};
        tbl[8] = '{32'h7F, 8'd1,  2'd1, 3'd3, 8'hF0, 64'h0BAD_F00D_1234_5678, 2'b00, 0, 0, 1};
        tbl[9] = '{32'h98, 8'd0,  2'd1, 3'd3, 8'hFF, 64'h3333_3333_3333_3333, 2'b10, 0, -1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ready", slave_aw_ready, 0);
        check("rst_ar_ready", slave_ar_ready, 0);
        check("rst_w_ready", slave_w_ready, 0);
        check("rst_b_valid", slave_b_valid, 0);
        check("rst_r_valid", slave_r_valid, 0);
        check("rst_r_last", slave_r_last, 0);
        check("rst_b_resp", slave_b_resp, 0);
        check("rst_r_resp", slave_r_resp, 0);
        check("rst_r_data", slave_r_data, 0);
        check("rst_ids", {slave_b_id, slave_r_id}, 0);
        check("rst_users", {slave_b_user, slave_r_user}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("aw_ready_after_rst", slave_aw_ready, 1);
        check("ar_ready_after_rst", slave_ar_ready, 1);

        foreach (tbl[i]) begin
            do_write(tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].size, tbl[i].strb, tbl[i].data,
                     int'(tbl[i].len), tbl[i].bstall, tbl[i].resp);
            model_write(tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].size, tbl[i].strb, tbl[i].data);
            do_read(tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].size, tbl[i].resp,
                    tbl[i].rstall_at, tbl[i].rstall_n);
        end

        // Early w_last on beat 2 of a 4-beat burst; strb 0 keeps memory untouched.
        do_write(32'h40, 8'd3, 2'd1, 3'd3, 8'h00, 64'h0, 1, 0, 2'b10);
        do_read(32'h40, 8'd3, 2'd1, 3'd3, 2'b00, -1, 0);

        // Read of word 3 stalled while a write to word 3 completes.
        old_w3 = model_mem[3];
        new_w3 = 64'hFEED_FACE_0BAD_BEEF;
        slave_r_ready = 1'b0;
        send_ar(32'h18, 8'd0, 2'd1, 3'd3, 10'h155, 6'h2A);
        check("stall_r_data_before", slave_r_data, old_w3);
        do_write(32'h18, 8'd0, 2'd1, 3'd3, 8'hFF, new_w3, 0, 0, 2'b00);
        model_write(32'h18, 8'd0, 2'd1, 3'd3, 8'hFF, new_w3);
        check("stall_r_valid", slave_r_valid, 1);
        check("stall_r_data_after_write", slave_r_data, old_w3);
        check("stall_r_last", slave_r_last, 1);
        slave_r_ready = 1'b1;
        @(posedge clk); #1;
        slave_r_ready = 1'b0;
        check("stall_r_valid_done", slave_r_valid, 0);
        do_read(32'h18, 8'd0, 2'd1, 3'd3, 2'b00, -1, 0);

        // Reset in W_DATA after one beat has landed in word 4.
        d = 64'h4444_5555_6666_7777;
        send_aw(32'h20, 8'd3, 2'd1, 3'd3, 10'h3FF, 6'h3F);
        send_w(d, 8'hFF, 1'b0);
        model_mem[4] = d;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_aw_ready", slave_aw_ready, 0);
        check("midrst_w_ready", slave_w_ready, 0);
        check("midrst_b_valid", slave_b_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_aw_ready_after", slave_aw_ready, 1);
        check("midrst_w_ready_after", slave_w_ready, 0);
        slave_b_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("midrst_no_b_valid", slave_b_valid, 0);
        end
        slave_b_ready = 1'b0;
        do_read(32'h20, 8'd1, 2'd1, 3'd3, 2'b00, -1, 0);

        for (int it = 0; it < 40; it++) begin
            a  = 32'($urandom_range(0, 159));
            l  = 8'($urandom_range(0, 6));
            bu = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            d  = {$urandom(), $urandom()};
            do_write(a, l, bu, sz, 8'($urandom_range(0, 255)), d, int'(l), $urandom_range(0, 2),
                     model_err(a, bu, sz) ? 2'b10 : 2'b00);
            model_write(a, l, bu, sz, slave_w_strb, d);
            do_read(a, l, bu, sz, model_err(a, bu, sz) ? 2'b10 : 2'b00,
                    $urandom_range(0, int'(l)), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named per codebase convention as clk and rst.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 64, data width.
- AXI_ID_WIDTH, 10, ID width.
- AXI_USER_WIDTH, 6, user width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width.
- MEM_DEPTH, 16, number of data words (power of 2).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, sync reset, active high.
- slave_aw_addr/len/size/burst/id/user/valid, in, ADDR/8/3/2/ID/USER/1, write address channel.
- slave_aw_prot/region/lock/cache/qos, in, 3/4/1/4/4, accepted and ignored.
- slave_aw_ready, out, 1.
- slave_w_data/strb/user/last/valid, in, DATA/STRB/USER/1/1, write data channel.
- slave_w_ready, out, 1.
- slave_b_resp/id/user/valid, out, 2/ID/USER/1, write response channel.
- slave_b_ready, in, 1.
- slave_ar_*, in, same set and widths as slave_aw_*, read address channel.
- slave_ar_ready, out, 1.
- slave_r_data/resp/last/id/user/valid, out, DATA/2/1/ID/USER/1, read data channel.
- slave_r_ready, in, 1.

Function
REQ-004 The write path SHALL be an FSM with states W_IDLE, W_DATA and W_RESP; the read path SHALL be an FSM with states R_IDLE and R_DATA; the two paths SHALL operate independently and concurrently.
REQ-005 The block SHALL assert slave_aw_ready only in W_IDLE. An AW handshake SHALL latch the word index (addr[log2(STRB) +: log2(MEM_DEPTH)]), len, id and user, clear the beat counter and enter W_DATA.
REQ-006 The block SHALL flag a write burst as error if any of these hold:
- burst != INCR (2'b01);
- size != log2(AXI_STRB_WIDTH);
- addr >= MEM_DEPTH*AXI_STRB_WIDTH.
REQ-007 In W_DATA the block SHALL assert slave_w_ready. Each W handshake SHALL:
- write the bytes whose strb bit is 1 to mem[index], unless the burst is flagged error;
- increment index modulo MEM_DEPTH (wrap-around);
- increment the beat counter.
REQ-008 The block SHALL end a write burst on the first beat where w_last=1 or beat counter == len, then enter W_RESP. If w_last and (counter == len) disagree on that beat, the burst SHALL be flagged error; remaining beats of the burst are not accepted.
REQ-009 In W_RESP the block SHALL hold slave_b_valid=1 with b_id/b_user as latched and b_resp=2'b00 (OKAY) or 2'b10 (SLVERR) when flagged, until b_ready=1, then return to W_IDLE.
REQ-010 The block SHALL assert slave_ar_ready only in R_IDLE. An AR handshake SHALL latch index, len, id and user, apply the REQ-006 error checks, and enter R_DATA.
REQ-011 The block SHALL register r_data from mem[index] in the AR handshake cycle and after every non-final R handshake, so the first r_valid appears 1 cycle after the AR handshake.
REQ-012 While r_valid=1 and r_ready=0, the block SHALL hold r_data, r_resp, r_last, r_id and r_user stable, including across concurrent writes to the same word.
REQ-013 The block SHALL drive r_last=1 when beat counter == len, and r_resp=2'b10 with r_data=0 for every beat of an error burst. The final R handshake SHALL return the read path to R_IDLE with r_valid=0 in the next cycle.
REQ-014 The block SHALL complete exactly len+1 read beats.
REQ-015 Index SHALL wrap from MEM_DEPTH-1 to 0 for both reads and writes.

Reset
REQ-016 While rst=1 at a clk edge, the block SHALL:
- set both FSMs to their IDLE states;
- drive aw_ready, ar_ready, w_ready, b_valid, r_valid and r_last to 0;
- drive b_resp, r_resp, r_data, b_id, r_id and the user outputs to 0.
REQ-017 aw_ready and ar_ready SHALL first be 1 in the first cycle after rst falls. Reset mid-burst SHALL abandon the burst with no response.
REQ-018 Memory contents SHALL NOT be reset.

Verification
REQ-019 Single write then read: write addr 0x08, len 0, data 0x1122334455667788, strb 0xFF -> b_resp 00; read of 0x08 -> r_data 0x1122334455667788, r_last=1, r_resp 00.
REQ-020 Wrap burst with strobes: write addr 0x70, len 3, strb 0x0F -> words 14, 15, 0, 1 get low bytes only; a 4-beat read returns them in order with r_last only on beat 4.
REQ-021 Errors: write addr 0x80 -> b_resp 10, memory unchanged; read with burst FIXED -> all beats r_resp 10, r_data 0; w_last on beat 2 of a len-3 burst -> burst ends, b_resp 10.
REQ-022 Backpressure: hold b_ready=0 for 5 cycles and r_ready=0 for 3 cycles mid-burst -> outputs stable, aw_ready stays 0 until the B handshake, no beat lost.
REQ-023 Concurrency and reset: a read of word 3 stalled while a write to word 3 completes -> stalled r_data keeps the old value; rst pulsed in W_DATA -> b_valid never asserts, aw_ready=1 in the cycle after rst falls.
